// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, debounce and one-cycle key codes.
// Optional auto-repeat while a key is held is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned DEBOUNCE_CNT = 1000,
  parameter int unsigned REPEAT_DELAY = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] button,
  output logic       key_valid
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DwellW-1:0] DwellLast   = DwellW'(SCAN_DIV - 1);
  localparam logic [DwellW-1:0] DwellSettle = DwellW'(3);
  localparam logic [DbW-1:0]    DbLast      = DbW'(DEBOUNCE_CNT - 1);
  localparam logic [DbW-1:0]    DbMax       = {DbW{1'b1}};

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_DELAY < 2) begin : gen_param_check
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {StScan, StDebounce, StEmit, StHold} state_e;

  state_e              state_q;
  logic [3:0]          row_meta_q;
  logic [3:0]          row_s_q;
  logic [1:0]          col_q;
  logic [1:0]          row_q;
  logic [3:0]          pat_q;
  logic [DwellW-1:0]   dwell_q;
  logic [DbW-1:0]      db_q;
  logic [3:0]          col_out_q;
  logic [7:0]          button_q;
  logic                valid_q;

  logic [1:0]          low_row;
  logic                row_any_low;
  logic                row_match;
  logic                row_released;
  logic [1:0]          col_inc;
  logic [3:0]          col_inc_drive;
  logic [DbW-1:0]      db_inc;
  logic [7:0]          key_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
    end else begin
      row_meta_q <= row_in;
      row_s_q    <= row_meta_q;
    end
  end

  // Lowest-index low row wins when several rows of one column are pressed.
  always_comb begin
    low_row = 2'd3;
    if (!row_s_q[0]) begin
      low_row = 2'd0;
    end else if (!row_s_q[1]) begin
      low_row = 2'd1;
    end else if (!row_s_q[2]) begin
      low_row = 2'd2;
    end
  end

  assign row_any_low   = ~&row_s_q;
  assign row_match     = (row_s_q == pat_q);
  assign row_released  = (row_s_q == 4'hF);
  assign col_inc       = col_q + 2'd1;
  assign col_inc_drive = ~(4'b0001 << col_inc);
  assign db_inc        = (db_q == DbMax) ? db_q : db_q + 1'b1;
  assign key_code      = {2'b00, col_q, 2'b01, row_q};

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_DELAY - 1);

  logic [RepW-1:0] rep_q;
  logic            rep_on_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StScan;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      pat_q     <= 4'hF;
      dwell_q   <= '0;
      db_q      <= '0;
      col_out_q <= 4'b1110;
      button_q  <= 8'h00;
      valid_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
      rep_on_q  <= 1'b0;
`endif
    end else begin
      button_q <= 8'h00;
      valid_q  <= 1'b0;
      unique case (state_q)
        StScan: begin
          if (dwell_q >= DwellSettle && row_any_low) begin
            row_q   <= low_row;
            pat_q   <= row_s_q;
            db_q    <= '0;
            state_q <= StDebounce;
          end else if (dwell_q == DwellLast) begin
            dwell_q   <= '0;
            col_q     <= col_inc;
            col_out_q <= col_inc_drive;
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end

        StDebounce: begin
          if (!row_match) begin
            state_q   <= StScan;
            dwell_q   <= '0;
            col_q     <= col_inc;
            col_out_q <= col_inc_drive;
          end else if (db_q == DbLast) begin
            state_q  <= StEmit;
            button_q <= key_code;
            valid_q  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rep_q    <= '0;
            rep_on_q <= 1'b1;
`endif
          end else begin
            db_q <= db_inc;
          end
        end

        StEmit: begin
          state_q <= StHold;
          db_q    <= '0;
`ifdef KEYPAD_REPEAT_EN
          if (row_match) begin
            rep_q <= rep_q + 1'b1;
          end else begin
            rep_on_q <= 1'b0;
          end
`endif
        end

        StHold: begin
          if (row_released) begin
            if (db_q == DbLast) begin
              state_q   <= StScan;
              db_q      <= '0;
              dwell_q   <= '0;
              col_q     <= col_inc;
              col_out_q <= col_inc_drive;
            end else begin
              db_q <= db_inc;
            end
          end else begin
            db_q <= '0;
          end
`ifdef KEYPAD_REPEAT_EN
          // Timer runs only while the original pattern is still held unchanged.
          if (rep_on_q && row_match) begin
            if (rep_q == RepLast) begin
              state_q  <= StEmit;
              button_q <= key_code;
              valid_q  <= 1'b1;
              rep_q    <= '0;
            end else begin
              rep_q <= rep_q + 1'b1;
            end
          end else begin
            rep_on_q <= 1'b0;
          end
`endif
        end

        default: state_q <= StScan;
      endcase
    end
  end

  assign col_out   = col_out_q;
  assign button    = button_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model closes rows against the driven column.
// Expected pulse counts follow KEYPAD_REPEAT_EN when the bench is built with it.
module tb_keypad_scanner;

  localparam int unsigned ScanDiv     = 4;
  localparam int unsigned DebounceCnt = 8;
  localparam int unsigned RepeatDelay = 50;

`ifdef KEYPAD_REPEAT_EN
  localparam int T2Pulses = 4;
  localparam int T6Pulses = 4;
`else
  localparam int T2Pulses = 1;
  localparam int T6Pulses = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] button;
  logic       key_valid;

  logic [15:0] keys;
  logic        key_en;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int   pulse_cnt = 0;
  int   viol      = 0;
  logic prev_valid = 1'b0;
  logic [7:0] pulse_code [0:31];
  int         pulse_cyc  [0:31];

  keypad_scanner #(
    .SCAN_DIV    (ScanDiv),
    .DEBOUNCE_CNT(DebounceCnt),
    .REPEAT_DELAY(RepeatDelay)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .button   (button),
    .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Key index is row*4 + col; a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_en && keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (pulse_cnt < 32) begin
        pulse_code[pulse_cnt] = button;
        pulse_cyc[pulse_cnt]  = cyc;
      end
      pulse_cnt = pulse_cnt + 1;
      if (prev_valid === 1'b1) viol = viol + 1;
    end
    if (key_valid !== (button != 8'h00)) viol = viol + 1;
    prev_valid = key_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] target, input int budget);
    int n = 0;
    @(negedge clk);
    while (col_out !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n = 0;
    while (pulse_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n0;
    int t0;
    int t1;
    int te;
    logic [3:0] c1;

    keys   = 16'h0000;
    key_en = 1'b1;
    rst_n  = 1'b1;

    // 1: reset values, held and on release
    #1 rst_n = 1'b0;
    #2;
    check("rst_col", 32'(col_out), 32'h0000_000E);
    check("rst_button", 32'(button), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    cycles(3);
    check("rst_held_col", 32'(col_out), 32'h0000_000E);
    rst_n = 1'b1;
    cycles(1);
    check("rst_rel_col", 32'(col_out), 32'h0000_000E);
    check("rst_rel_valid", 32'(key_valid), 32'h0);
    cycles(3);
    check("rst_rotate", 32'(col_out), 32'h0000_000D);

    // 2: single press of "5" (row 2, col 1)
    wait_col(4'b1110, 20);
    n0 = pulse_cnt;
    keys[9] = 1'b1;
    wait_col(4'b1101, 20);
    check("t2_col1", 32'(col_out), 32'h0000_000D);
    t0 = cyc;
    wait_pulses(n0 + 1, 40);
    check("t2_code", 32'(pulse_code[n0]), 32'h16);
    check("t2_latency", 32'(pulse_cyc[n0] - t0), 32'd12);
    while (cyc < t0 + 200) @(negedge clk);
    check("t2_frozen", 32'(col_out), 32'h0000_000D);
    keys = 16'h0000;
    t1 = cyc;
    wait_col(4'b1011, 30);
    check("t2_resume_col", 32'(col_out), 32'h0000_000B);
    check("t2_release_time", 32'(cyc - t1), 32'd10);
    check("t2_pulses", 32'(pulse_cnt - n0), 32'(T2Pulses));

    // 3: bouncing "Clear" never settles for a full debounce window
    n0 = pulse_cnt;
    keys[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      key_en = 1'b1;
      cycles(5);
      key_en = 1'b0;
      cycles(1);
    end
    keys   = 16'h0000;
    key_en = 1'b1;
    cycles(20);
    check("t3_no_pulse", 32'(pulse_cnt - n0), 32'd0);
    c1 = col_out;
    check("t3_onehot", 32'($countones(~c1)), 32'd1);
    cycles(4);
    check("t3_rotate", 32'(col_out), 32'({c1[2:0], c1[3]}));

    // 4: rows 1 and 3 on column 3; row 1 ("*") wins
    n0 = pulse_cnt;
    keys[7]  = 1'b1;
    keys[15] = 1'b1;
    wait_pulses(n0 + 1, 60);
    cycles(40);
    check("t4_pulses", 32'(pulse_cnt - n0), 32'd1);
    check("t4_code", 32'(pulse_code[n0]), 32'h35);
    keys = 16'h0000;
    cycles(20);

    // 5: reset four cycles into the debounce of "=" (row 0, col 2)
    wait_col(4'b1110, 20);
    n0 = pulse_cnt;
    keys[2] = 1'b1;
    wait_col(4'b1011, 20);
    t0 = cyc;
    while (cyc < t0 + 8) @(negedge clk);
    check("t5_no_early", 32'(pulse_cnt - n0), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t5_async_col", 32'(col_out), 32'h0000_000E);
    check("t5_async_valid", 32'(key_valid), 32'h0);
    cycles(3);
    rst_n = 1'b1;
    wait_pulses(n0 + 1, 60);
    cycles(20);
    check("t5_pulses", 32'(pulse_cnt - n0), 32'd1);
    check("t5_code", 32'(pulse_code[n0]), 32'h24);
    keys = 16'h0000;
    cycles(20);

    // 6: hold "+" (row 3, col 3) for 180 cycles past the first pulse
    n0 = pulse_cnt;
    keys[15] = 1'b1;
    wait_pulses(n0 + 1, 60);
    check("t6_first_code", 32'(pulse_code[n0]), 32'h37);
    te = pulse_cyc[n0];
    while (cyc < te + 180) @(negedge clk);
    keys = 16'h0000;
    cycles(20);
    check("t6_pulses", 32'(pulse_cnt - n0), 32'(T6Pulses));
`ifdef KEYPAD_REPEAT_EN
    for (int k = 1; k < 4; k++) begin
      check("t6_rep_code", 32'(pulse_code[n0+k]), 32'h37);
      check("t6_rep_time", 32'(pulse_cyc[n0+k] - te), 32'(k * 50));
    end
`endif

    check("pulse_shape", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
